// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response codes, arbiter state encoding and requester indices.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IFU_RD   = 3'd1,
    ST_LSU_RD   = 3'd2,
    ST_LSU_WR   = 3'd3,
    ST_WAIT_END = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned REQ_IFU = 0;
  localparam int unsigned REQ_LSU = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational one-hot grant, registered last-served bit.
// Zero latency from request to grant; last-served only moves on an explicit update pulse.
module rr_arb2
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_vld_i,
  input  logic       upd_lsu_i,
  output logic [1:0] gnt_o
);

  // last_q = 1 means the LSU was served last, so the IFU wins the next tie
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd_vld_i) last_d = upd_lsu_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o[REQ_IFU] = 1'b1;
      2'b10:   gnt_o[REQ_LSU] = 1'b1;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_arbiter.sv
// IFU/LSU to single AXI4-Lite slave arbiter, one transaction outstanding; 1 cycle grant, 0 added on R/B.
// Backpressure passes straight through from the slave to the owning master; non-owners see ready=0.
module axi_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr,
  input  logic                  lsu_awvalid,
  output logic                  lsu_awready,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] req, gnt;
  logic       upd_vld, upd_lsu;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req   = {lsu_arvalid | lsu_awvalid, ifu_arvalid};
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .upd_vld_i (upd_vld),
    .upd_lsu_i (upd_lsu),
    .gnt_o     (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    upd_vld   = 1'b0;
    upd_lsu   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt[REQ_IFU])      state_d = ST_IFU_RD;
        else if (gnt[REQ_LSU]) state_d = lsu_arvalid ? ST_LSU_RD : ST_LSU_WR;
      end
      ST_IFU_RD, ST_LSU_RD: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          state_d = ST_WAIT_END;
          upd_vld = 1'b1;
          upd_lsu = (state_q == ST_LSU_RD);
        end
      end
      ST_LSU_WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (b_hs) begin
          state_d = ST_WAIT_END;
          upd_vld = 1'b1;
          upd_lsu = 1'b1;
        end
      end
      ST_WAIT_END: begin
        state_d   = ST_IDLE;
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the owner's channels are wired through; IDLE and WAIT_END leave everything quiet.
  always_comb begin
    ifu_arready = 1'b0;  ifu_rdata = '0;  ifu_rresp = '0;  ifu_rvalid = 1'b0;
    lsu_arready = 1'b0;  lsu_rdata = '0;  lsu_rresp = '0;  lsu_rvalid = 1'b0;
    lsu_awready = 1'b0;  lsu_wready = 1'b0;  lsu_bresp = '0;  lsu_bvalid = 1'b0;
    s_araddr = '0;  s_arvalid = 1'b0;  s_rready = 1'b0;
    s_awaddr = '0;  s_awvalid = 1'b0;
    s_wdata  = '0;  s_wstrb   = '0;    s_wvalid = 1'b0;  s_bready = 1'b0;
    case (state_q)
      ST_IFU_RD: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid & ~ar_done_q;
        ifu_arready = s_arready & ~ar_done_q;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
      end
      ST_LSU_RD: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid & ~ar_done_q;
        lsu_arready = s_arready & ~ar_done_q;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
      end
      ST_LSU_WR: begin
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid & ~aw_done_q;
        lsu_awready = s_awready & ~aw_done_q;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid & ~w_done_q;
        lsu_wready  = s_wready & ~w_done_q;
        lsu_bresp   = s_bresp;
        lsu_bvalid  = s_bvalid & aw_done_q & w_done_q;
        s_bready    = lsu_bready & aw_done_q & w_done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed scoreboard bench for axi_arbiter: masters and a slave model driven from the bench,
// expected grants/beats/responses queued at issue time and checked by a negedge monitor.
module tb_axi_arbiter;
  import axi_pkg::*;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
  logic        lsu_awvalid, lsu_wvalid, lsu_bready;
  logic [3:0]  lsu_wstrb;
  logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
  logic        lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [3:0]  s_wstrb;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [1:0]  s_rresp, s_bresp;

  int n_vec = 0;
  int n_err = 0;
  int rd_lat = 3;

  // Scoreboard: {owner(0 IFU,1 LSU rd,2 LSU wr), addr}, R {resp,data}, W {strb,data}, B resp
  logic [33:0] exp_gnt[$];
  logic [33:0] exp_ifu_r[$];
  logic [33:0] exp_lsu_r[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_lsu_b[$];
  logic [33:0] slv_mem[logic [31:0]];
  logic [1:0]  slv_bresp[logic [31:0]];

  always #5 clk = ~clk;

  axi_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endfunction

  function automatic logic outs_any();
    return |{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rdata, lsu_rresp,
             lsu_rvalid, lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid, s_araddr, s_arvalid,
             s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};
  endfunction

  // Slave model: readies pulse one cycle after valid, R after rd_lat, B after both AW and W.
  initial begin
    logic v_ar, h_ar, h_r, v_aw, h_aw, v_w, h_w, h_b, r_pend, aw_seen, w_seen;
    logic [31:0] a_addr, aw_addr, r_addr, b_addr;
    int r_cnt;
    r_pend = 0; aw_seen = 0; w_seen = 0; r_cnt = 0; r_addr = 0; b_addr = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_awready = 0;
    s_wready = 0; s_bvalid = 0; s_bresp = 0;
    forever begin
      @(negedge clk);
      v_ar = s_arvalid; h_ar = s_arvalid && s_arready; a_addr = s_araddr;
      h_r  = s_rvalid && s_rready;
      v_aw = s_awvalid; h_aw = s_awvalid && s_awready; aw_addr = s_awaddr;
      v_w  = s_wvalid;  h_w  = s_wvalid && s_wready;
      h_b  = s_bvalid && s_bready;
      @(posedge clk); #1;
      if (!reset) begin
        r_pend = 0; aw_seen = 0; w_seen = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
      end else begin
        s_arready = v_ar && !s_arready;
        if (h_ar) begin r_pend = 1; r_cnt = rd_lat; r_addr = a_addr; end
        if (h_r) s_rvalid = 0;
        else if (r_pend) begin
          if (r_cnt == 0) begin
            s_rvalid = 1;
            {s_rresp, s_rdata} = slv_mem.exists(r_addr) ? slv_mem[r_addr] : {RESP_DECERR, 32'h0};
            r_pend = 0;
          end else r_cnt--;
        end
        s_awready = v_aw && !s_awready;
        if (h_aw) begin aw_seen = 1; b_addr = aw_addr; end
        s_wready = v_w && !s_wready;
        if (h_w) w_seen = 1;
        if (h_b) s_bvalid = 0;
        else if (aw_seen && w_seen) begin
          s_bvalid = 1;
          s_bresp  = slv_bresp.exists(b_addr) ? slv_bresp[b_addr] : RESP_OKAY;
          aw_seen = 0; w_seen = 0;
        end
      end
    end
  end

  // Monitor: grant order, beats, responses and per-cycle ownership invariants.
  initial begin
    logic ar_wait, viol;
    logic [31:0] ar_addr_q;
    logic [1:0] owner;
    arb_state_e st;
    ar_wait = 0; ar_addr_q = 0;
    forever begin
      @(negedge clk);
      if (!reset) ar_wait = 0;
      else begin
        st = dut.state_q;
        if (ar_wait) check("s_arvalid_stable", {s_arvalid, s_araddr}, {1'b1, ar_addr_q});
        ar_wait = s_arvalid && !s_arready;
        ar_addr_q = s_araddr;
        if (s_arvalid && s_arready) begin
          owner = ifu_arready ? 2'd0 : (lsu_arready ? 2'd1 : 2'd3);
          if (exp_gnt.size() == 0) timeout("unexpected_ar_handshake");
          else check("grant_ar", {owner, s_araddr}, exp_gnt.pop_front());
        end
        if (s_awvalid && s_awready) begin
          owner = lsu_awready ? 2'd2 : 2'd3;
          if (exp_gnt.size() == 0) timeout("unexpected_aw_handshake");
          else check("grant_aw", {owner, s_awaddr}, exp_gnt.pop_front());
        end
        if (s_wvalid && s_wready) begin
          if (exp_w.size() == 0) timeout("unexpected_w_handshake");
          else check("w_beat", {s_wstrb, s_wdata}, exp_w.pop_front());
        end
        if (ifu_rvalid && ifu_rready) begin
          if (exp_ifu_r.size() == 0) timeout("unexpected_ifu_r");
          else check("ifu_r", {ifu_rresp, ifu_rdata}, exp_ifu_r.pop_front());
        end
        if (lsu_rvalid && lsu_rready) begin
          if (exp_lsu_r.size() == 0) timeout("unexpected_lsu_r");
          else check("lsu_r", {lsu_rresp, lsu_rdata}, exp_lsu_r.pop_front());
        end
        if (lsu_bvalid && lsu_bready) begin
          check("b_after_w", exp_w.size(), 0);
          if (exp_lsu_b.size() == 0) timeout("unexpected_lsu_b");
          else check("lsu_bresp", lsu_bresp, exp_lsu_b.pop_front());
        end
        viol = 0;
        if (st > ST_WAIT_END) viol = 1;
        if (st != ST_IFU_RD && (ifu_arready || ifu_rvalid)) viol = 1;
        if (st != ST_LSU_RD && (lsu_arready || lsu_rvalid)) viol = 1;
        if (st != ST_LSU_WR && (lsu_awready || lsu_wready || lsu_bvalid)) viol = 1;
        if ((st == ST_IDLE || st == ST_WAIT_END) &&
            (s_arvalid || s_rready || s_awvalid || s_wvalid || s_bready)) viol = 1;
        if ((st == ST_IFU_RD || st == ST_LSU_RD) && (s_awvalid || s_wvalid || s_bready)) viol = 1;
        if (st == ST_LSU_WR && (s_arvalid || s_rready)) viol = 1;
        check("ownership_invariant", viol, 0);
      end
    end
  end

  task automatic ifu_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int t;
    slv_mem[addr] = {resp, data};
    exp_ifu_r.push_back({resp, data});
    @(posedge clk); #1;
    ifu_araddr = addr; ifu_arvalid = 1; ifu_rready = 1;
    t = 0; do begin @(negedge clk); t++; end while (!ifu_arready && t < TMO);
    if (!ifu_arready) timeout("ifu_arready");
    @(posedge clk); #1;
    ifu_arvalid = 0; ifu_araddr = 0;
    t = 0; do begin @(negedge clk); t++; end while (!ifu_rvalid && t < TMO);
    if (!ifu_rvalid) timeout("ifu_rvalid");
    @(posedge clk); #1;
  endtask

  task automatic lsu_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int t;
    slv_mem[addr] = {resp, data};
    exp_lsu_r.push_back({resp, data});
    @(posedge clk); #1;
    lsu_araddr = addr; lsu_arvalid = 1; lsu_rready = 1;
    t = 0; do begin @(negedge clk); t++; end while (!lsu_arready && t < TMO);
    if (!lsu_arready) timeout("lsu_arready");
    @(posedge clk); #1;
    lsu_arvalid = 0; lsu_araddr = 0;
    t = 0; do begin @(negedge clk); t++; end while (!lsu_rvalid && t < TMO);
    if (!lsu_rvalid) timeout("lsu_rvalid");
    @(posedge clk); #1;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input int wdly);
    int t;
    slv_bresp[addr] = resp;
    exp_w.push_back({strb, data});
    exp_lsu_b.push_back(resp);
    @(posedge clk); #1;
    lsu_awaddr = addr; lsu_awvalid = 1; lsu_bready = 1;
    fork
      begin
        int ta;
        ta = 0; do begin @(negedge clk); ta++; end while (!lsu_awready && ta < TMO);
        if (!lsu_awready) timeout("lsu_awready");
        @(posedge clk); #1;
        lsu_awvalid = 0;
      end
      begin
        int tw;
        repeat (wdly) @(posedge clk);
        #1;
        lsu_wdata = data; lsu_wstrb = strb; lsu_wvalid = 1;
        tw = 0; do begin @(negedge clk); tw++; end while (!lsu_wready && tw < TMO);
        if (!lsu_wready) timeout("lsu_wready");
        @(posedge clk); #1;
        lsu_wvalid = 0;
      end
    join
    t = 0; do begin @(negedge clk); t++; end while (!lsu_bvalid && t < TMO);
    if (!lsu_bvalid) timeout("lsu_bvalid");
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    int t;
    ifu_araddr = 0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = 0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0; lsu_bready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero", outs_any(), 0);
    check("reset_state_idle", dut.state_q, ST_IDLE);
    @(posedge clk); #1;
    reset = 1;
    repeat (2) @(negedge clk);
    check("idle_no_request_quiet", outs_any(), 0);

    // IFU-only read, then two-cycle return to IDLE
    exp_gnt.push_back({2'd0, 32'h0000_1000});
    ifu_read(32'h0000_1000, 32'h1234_5678, RESP_OKAY);
    check("wait_end_after_r", dut.state_q, ST_WAIT_END);
    @(posedge clk); #1;
    check("idle_2_after_r", dut.state_q, ST_IDLE);

    // Ties right after reset: IFU, LSU, then IFU again
    pulse_reset();
    exp_gnt.push_back({2'd0, 32'h0000_2000});
    exp_gnt.push_back({2'd1, 32'h0000_3000});
    fork
      ifu_read(32'h0000_2000, 32'hcafe_0001, RESP_OKAY);
      lsu_read(32'h0000_3000, 32'h0bad_0002, RESP_DECERR);
    join
    exp_gnt.push_back({2'd0, 32'h0000_2004});
    exp_gnt.push_back({2'd1, 32'h0000_3004});
    fork
      ifu_read(32'h0000_2004, 32'hcafe_0003, RESP_SLVERR);
      lsu_read(32'h0000_3004, 32'h0bad_0004, RESP_OKAY);
    join

    // Write with W two cycles behind AW, SLVERR passed back
    exp_gnt.push_back({2'd2, 32'ha000_2000});
    lsu_write(32'ha000_2000, 32'hdead_beef, 4'hf, RESP_SLVERR, 2);

    // LSU read and write raised together: read first
    exp_gnt.push_back({2'd1, 32'h0000_4000});
    exp_gnt.push_back({2'd2, 32'h0000_5000});
    fork
      lsu_read(32'h0000_4000, 32'h55aa_55aa, RESP_OKAY);
      lsu_write(32'h0000_5000, 32'h1111_2222, 4'h3, RESP_OKAY, 0);
    join

    // Reset while the slave holds R valid and the IFU withholds rready
    slv_mem[32'h0000_6000] = {RESP_OKAY, 32'hfeed_f00d};
    exp_gnt.push_back({2'd0, 32'h0000_6000});
    @(posedge clk); #1;
    ifu_araddr = 32'h0000_6000; ifu_arvalid = 1; ifu_rready = 0;
    t = 0; do begin @(negedge clk); t++; end while (!ifu_arready && t < TMO);
    if (!ifu_arready) timeout("mid_reset_arready");
    @(posedge clk); #1;
    ifu_arvalid = 0; ifu_araddr = 0;
    t = 0; do begin @(negedge clk); t++; end while (!s_rvalid && t < TMO);
    if (!s_rvalid) timeout("mid_reset_s_rvalid");
    check("mid_reset_pending_r", ifu_rvalid, 1);
    reset = 0;
    #1;
    check("mid_reset_outputs_zero", outs_any(), 0);
    check("mid_reset_state_idle", dut.state_q, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    ifu_rready = 1;
    reset = 1;
    exp_gnt.push_back({2'd0, 32'h0000_7000});
    ifu_read(32'h0000_7000, 32'h89ab_cdef, RESP_OKAY);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("grants_drained", exp_gnt.size(), 0);
    check("ifu_r_drained", exp_ifu_r.size(), 0);
    check("lsu_r_drained", exp_lsu_r.size(), 0);
    check("lsu_b_drained", exp_lsu_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 ifu_araddr/ifu_arvalid  in  ADDR_WIDTH/1; ifu_arready  out  1  IFU read-address channel.
REQ-006 ifu_rdata/ifu_rresp/ifu_rvalid  out  DATA_WIDTH/2/1; ifu_rready  in  1  IFU read-data channel.
REQ-007 lsu_araddr/lsu_arvalid  in; lsu_arready  out  LSU read-address channel.
REQ-008 lsu_rdata/lsu_rresp/lsu_rvalid  out; lsu_rready  in  LSU read-data channel.
REQ-009 lsu_awaddr/lsu_awvalid  in; lsu_awready  out  LSU write-address channel.
REQ-010 lsu_wdata/lsu_wstrb(4)/lsu_wvalid  in; lsu_wready  out  LSU write-data channel.
REQ-011 lsu_bresp/lsu_bvalid  out; lsu_bready  in  LSU write-response channel.
REQ-012 s_ar*/s_r*/s_aw*/s_w*/s_b*  mirror of REQ-007..011 with direction reversed  single downstream AXI4-Lite slave port (crossbar toward CLINT/UART/SRAM).

Function
REQ-013 States SHALL be IDLE, IFU_RD, LSU_RD, LSU_WR, WAIT_END; exactly one transaction outstanding at a time.
REQ-014 In IDLE the arbiter SHALL sample requests (ifu_arvalid; lsu_arvalid or lsu_awvalid) and register a grant, entering the grant state on the next posedge; all master readys are 0 in IDLE.
REQ-015 IFU vs LSU contention: round-robin via last_grant bit (reset value LSU, so IFU wins the first tie); a sole requester is granted regardless of last_grant.
REQ-016 Within LSU, lsu_arvalid beats lsu_awvalid when both are asserted.
REQ-017 In a grant state the granted master's request and response channels SHALL be connected combinationally to s_*; non-granted master readys and valids SHALL be 0, s_* valids driven only by the owner.
REQ-018 IFU_RD/LSU_RD: AR forwarded until s_arvalid&&s_arready, then s_arvalid held 0; state leaves on s_rvalid&&s_rready.
REQ-019 LSU_WR: AW and W forwarded independently, per-channel done flags set on each handshake and suppressing re-forwarding; s_bready=lsu_bready only after both done; state leaves on s_bvalid&&s_bready.
REQ-020 On response handshake the arbiter SHALL go to WAIT_END for one cycle (all readys/valids 0), then IDLE, and update last_grant to the master just served.
REQ-021 rresp/bresp (OKAY 00, SLVERR 10, DECERR 11) SHALL pass through unmodified; rdata SHALL not be registered (zero added latency on R/B).
REQ-022 A master deasserting valid before its handshake is a protocol error; the arbiter SHALL keep the grant and not time out.
REQ-023 Minimum arbitration overhead: 1 cycle (IDLE) before AR/AW, 1 cycle (WAIT_END) after response; back-to-back requests from alternating masters SHALL each be served.

Reset
REQ-024 On reset=0: state=IDLE, last_grant=LSU, done flags=0, all *ready and *valid outputs=0, data/resp outputs=0.
REQ-025 Reset asserted mid-transaction SHALL abandon it immediately; after reset release, the first grant follows REQ-015 with no residual response routing.

Structure
REQ-026 Response codes and the state enum SHALL reside in the shared package axi_pkg (replacing the per-file resp-code defines).
REQ-027 Request selection SHALL be a sub-module rr_arb2 (2-input round-robin, registered last_grant, one-hot grant out); channel muxing stays in axi_arbiter.

Verification
REQ-028 IFU read only, slave returns rdata=0x12345678 OKAY after 3 cycles -> ifu_rdata=0x12345678, lsu_rvalid never 1, state back in IDLE 2 cycles after R handshake.
REQ-029 IFU and LSU arvalid same cycle after reset -> IFU granted first, LSU granted next; repeat tie -> IFU again (alternation).
REQ-030 LSU write awaddr=0xa0002000, wdata=0xdeadbeef, wstrb=0xF, W presented 2 cycles after AW -> one s_aw and one s_w handshake each, lsu_bvalid only after both, bresp=SLVERR passed through.
REQ-031 LSU arvalid and awvalid together -> read completes first, write granted on a later IDLE.
REQ-032 reset=0 asserted while s_rvalid pending -> all outputs 0 in the same cycle; after release a new IFU read completes correctly.
REQ-033 Assertions throughout: no valid/ready on a non-granted master; at most one of IFU_RD/LSU_RD/LSU_WR active; s_arvalid stable until handshake.
